reaction_ctrl: RTL

REACTION_CTRL -- requirements
Module: reaction_ctrl

---
 rtl/reaction_if.sv | 25 ++
 rtl/reaction_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/reaction_if.sv
// Bus between the reaction-timer controller and its surroundings: pulse inputs,
// random seed and the round status/result outputs.
interface reaction_if;
  logic        tick_1ms;
  logic        start;
  logic        react;
  logic [11:0] lfsr_val;
  logic        stim_led;
  logic        busy;
  logic [13:0] rt_ms;
  logic [13:0] best_ms;
  logic        result_valid;
  logic        false_start;
  logic        timeout;

  modport master (
    output tick_1ms, start, react, lfsr_val,
    input  stim_led, busy, rt_ms, best_ms, result_valid, false_start, timeout
  );

  modport slave (
    input  tick_1ms, start, react, lfsr_val,
    output stim_led, busy, rt_ms, best_ms, result_valid, false_start, timeout
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random pre-stimulus delay, stimulus, then
// measures the player's response in ms and tracks the best result.
module reaction_ctrl #(
  parameter int unsigned MIN_DELAY = 500,
  parameter int unsigned MAX_TIME  = 9999
) (
  input logic       clk,
  input logic       rst,
  reaction_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StWait, StStim, StDone, StFault} state_e;

  localparam logic [12:0] MinDelay = 13'(MIN_DELAY);
  localparam logic [13:0] MaxTime  = 14'(MAX_TIME);
  localparam logic [13:0] BestNone = 14'h3FFF;

  state_e      state_q, state_d;
  logic [12:0] delay_q, delay_d;
  logic [13:0] rt_cnt_q, rt_cnt_d;
  logic [13:0] rt_ms_q, rt_ms_d;
  logic [13:0] best_q, best_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      delay_q   <= '0;
      rt_cnt_q  <= '0;
      rt_ms_q   <= '0;
      best_q    <= BestNone;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      rt_cnt_q  <= rt_cnt_d;
      rt_ms_q   <= rt_ms_d;
      best_q    <= best_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    rt_cnt_d  = rt_cnt_q;
    rt_ms_d   = rt_ms_q;
    best_d    = best_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    case (state_q)
      // react is ignored here, so start alone decides the transition
      StIdle, StDone, StFault: begin
        if (bus.start) begin
          delay_d   = MinDelay + {1'b0, bus.lfsr_val};
          rt_cnt_d  = '0;
          timeout_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (bus.react) begin
          state_d = StFault;
        end else if (bus.tick_1ms) begin
          if (delay_q <= 13'd1) begin
            delay_d  = '0;
            rt_cnt_d = '0;
            state_d  = StStim;
          end else begin
            delay_d = delay_q - 13'd1;
          end
        end
      end
      StStim: begin
        // react wins over a coincident tick so the pre-increment count is captured
        if (bus.react) begin
          rt_ms_d = rt_cnt_q;
          valid_d = 1'b1;
          if (rt_cnt_q < best_q) best_d = rt_cnt_q;
          state_d = StDone;
        end else if (bus.tick_1ms) begin
          if (rt_cnt_q + 14'd1 == MaxTime) begin
            rt_cnt_d  = MaxTime;
            rt_ms_d   = MaxTime;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
            state_d   = StDone;
          end else begin
            rt_cnt_d = rt_cnt_q + 14'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.stim_led     = (state_q == StStim);
  assign bus.busy         = (state_q == StWait) || (state_q == StStim);
  assign bus.false_start  = (state_q == StFault);
  assign bus.timeout      = timeout_q;
  assign bus.rt_ms        = rt_ms_q;
  assign bus.best_ms      = best_q;
  assign bus.result_valid = valid_q;

endmodule
